// File: rtl/uart_rx_fifo.sv
// Tagged first-word-fall-through receive buffer behind a UART receiver, with RTS flow control.
// Optional saturating drop/error statistics are built when UART_RX_FIFO_STATS_EN is defined.
module uart_rx_fifo #(
    parameter int DataBits        = 8,
    parameter int Depth           = 16,
    parameter int AlmostFullLevel = 12
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [DataBits-1:0]          in_data,
    input  logic                         in_valid,
    input  logic                         in_break,
    input  logic                         in_error,
    output logic [DataBits-1:0]          out_data,
    output logic                         out_err,
    output logic                         out_brk,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(Depth+1)-1:0]   count,
    output logic                         full,
    output logic                         rts_n,
    output logic                         overflow,
    input  logic                         clear_overflow,
    output logic [15:0]                  drop_count,
    output logic [15:0]                  err_count
);

    localparam int AW = $clog2(Depth);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(Depth + 1);
    localparam int EW = DataBits + 2;
    localparam logic [PW-1:0] AFL = PW'(AlmostFullLevel);

    typedef enum logic {
        LINE_OK  = 1'b0,
        IN_BREAK = 1'b1
    } brk_state_t;

    brk_state_t    state_q, state_d;
    logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_d, rd_ptr_d, count_d;
    logic [EW-1:0] mem [Depth];
    logic [EW-1:0] entry, head;
    logic          empty, pop, push_req, do_push, drop, brk_eff, err_eff;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = CW'(wr_ptr - rd_ptr);

    // Break collapse: only the first break pulse of a break run becomes an entry.
    always_comb begin
        state_d = state_q;
        brk_eff = 1'b0;
        case (state_q)
            LINE_OK: begin
                if (in_break) begin
                    brk_eff = 1'b1;
                    state_d = IN_BREAK;
                end
            end
            IN_BREAK: begin
                if (in_valid || in_error) state_d = LINE_OK;
            end
            default: state_d = LINE_OK;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= LINE_OK;
        else        state_q <= state_d;
    end

    assign err_eff  = in_error & ~brk_eff;
    assign push_req = brk_eff | in_error | in_valid;
    assign entry    = brk_eff ? {1'b1, 1'b0, {DataBits{1'b0}}} : {1'b0, err_eff, in_data};

    // Handshake: the head transfers on any cycle where out_valid and out_ready are both high;
    // out_valid never waits on out_ready, and out_ready while empty has no effect.
    assign pop      = ~empty & out_ready;
    assign do_push  = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;
    assign wr_ptr_d = wr_ptr + PW'(do_push);
    assign rd_ptr_d = rd_ptr + PW'(pop);
    assign count_d  = wr_ptr_d - rd_ptr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rts_n    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr_d;
            rd_ptr <= rd_ptr_d;
            rts_n  <= (count_d >= AFL);
            if (drop)                overflow <= 1'b1;
            else if (clear_overflow) overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= entry;
    end

    assign head      = mem[rd_ptr[AW-1:0]];
    assign out_valid = ~empty;
    assign out_data  = out_valid ? head[DataBits-1:0] : '0;
    assign out_err   = out_valid & head[DataBits];
    assign out_brk   = out_valid & head[DataBits+1];

`ifdef UART_RX_FIFO_STATS_EN
    logic [15:0] drop_q, err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q <= '0;
            err_q  <= '0;
        end else begin
            if (drop && drop_q != 16'hFFFF)               drop_q <= drop_q + 16'd1;
            if (do_push && err_eff && err_q != 16'hFFFF)  err_q  <= err_q + 16'd1;
        end
    end

    assign drop_count = drop_q;
    assign err_count  = err_q;
`else
    assign drop_count = 16'h0;
    assign err_count  = 16'h0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed scenarios plus randomized traffic against a queue-based model.
module tb_uart_rx_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AFL   = 12;
    localparam int W     = DW + 2;
    localparam int SW    = W + 9;
`ifdef UART_RX_FIFO_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0, in_break = 1'b0, in_error = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_err, out_brk, out_valid;
    logic          out_ready = 1'b0;
    logic [4:0]    count;
    logic          full, rts_n, overflow;
    logic          clear_overflow = 1'b0;
    logic [15:0]   drop_count, err_count;

    logic [W-1:0] exp_q[$];
    bit           m_in_brk, m_ovf;
    int           m_drop, m_err;
    int           n_checks = 0;
    int           n_errors = 0;

    uart_rx_fifo #(.DataBits(DW), .Depth(DEPTH), .AlmostFullLevel(AFL)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_break(in_break), .in_error(in_error), .out_data(out_data), .out_err(out_err),
        .out_brk(out_brk), .out_valid(out_valid), .out_ready(out_ready), .count(count),
        .full(full), .rts_n(rts_n), .overflow(overflow), .clear_overflow(clear_overflow),
        .drop_count(drop_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        exp_q.delete();
        m_in_brk = 1'b0;
        m_ovf    = 1'b0;
        m_drop   = 0;
        m_err    = 0;
    endtask

    function automatic logic [SW-1:0] exp_status();
        int n;
        logic [W-1:0] hd;
        n  = exp_q.size();
        hd = (n > 0) ? exp_q[0] : '0;
        return {(n > 0), hd, 5'(n), (n == DEPTH), (n >= AFL), m_ovf};
    endfunction

    function automatic logic [15:0] exp_drop();
        return STATS ? 16'(m_drop) : 16'h0;
    endfunction

    function automatic logic [15:0] exp_err();
        return STATS ? 16'(m_err) : 16'h0;
    endfunction

    // One clock: apply inputs at the falling edge, advance the model at the rising edge.
    task automatic drive(input logic v, input logic e, input logic b, input logic [DW-1:0] d,
                         input logic rdy, input logic clr);
        bit brk_acc, ev, was_full, popped, dropped;
        @(negedge clk);
        in_valid = v; in_error = e; in_break = b; in_data = d;
        out_ready = rdy; clear_overflow = clr;
        @(posedge clk);
        brk_acc  = b && !m_in_brk;
        ev       = brk_acc || e || v;
        was_full = (exp_q.size() == DEPTH);
        popped   = (exp_q.size() > 0) && rdy;
        dropped  = 1'b0;
        if (popped) void'(exp_q.pop_front());
        if (ev) begin
            if (!was_full || popped) begin
                exp_q.push_back(brk_acc ? {2'b10, {DW{1'b0}}} : {1'b0, e, d});
                if (!brk_acc && e && m_err < 65535) m_err++;
            end else begin
                dropped = 1'b1;
                if (m_drop < 65535) m_drop++;
            end
        end
        if (dropped)  m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        if (b && !m_in_brk)            m_in_brk = 1'b1;
        else if (m_in_brk && (v || e)) m_in_brk = 1'b0;
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2 && exp_q.size() > 0; i++) drive(0, 0, 0, '0, 1, 0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 0; in_error = 0; in_break = 0; out_ready = 0; clear_overflow = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_checks++; if (count !== 5'd0) begin n_errors++; $display("FAIL reset_count got=%0d exp=0", count); end
        n_checks++; if ({full, rts_n, overflow} !== 3'b000) begin n_errors++; $display("FAIL reset_flags got=%b exp=000", {full, rts_n, overflow}); end
        n_checks++; if (out_data !== '0) begin n_errors++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        n_checks++; if ({drop_count, err_count} !== 32'h0) begin n_errors++; $display("FAIL reset_counters got=%h/%h exp=0/0", drop_count, err_count); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_in_order();
        logic [DW-1:0] got[$];
        logic [DW-1:0] want[3];
        want[0] = 8'h41; want[1] = 8'h42; want[2] = 8'h43;
        drive(0, 0, 0, '0, 1, 0);
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL order_idle_valid got=%b exp=0", out_valid); end
        for (int i = 0; i < 3; i++) begin
            if (out_valid) got.push_back(out_data);
            drive(1, 0, 0, want[i], 1, 0);
            if (i == 0) begin
                n_checks++; if (out_valid !== 1'b1 || out_data !== 8'h41) begin n_errors++; $display("FAIL order_first_latency got=%b/%h exp=1/41", out_valid, out_data); end
            end
        end
        for (int i = 0; i < 3 && out_valid; i++) begin
            got.push_back(out_data);
            drive(0, 0, 0, '0, 1, 0);
        end
        n_checks++; if (got.size() != 3) begin n_errors++; $display("FAIL order_count got=%0d exp=3", got.size()); end
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            n_checks++; if (got[i] !== want[i]) begin n_errors++; $display("FAIL order_data[%0d] got=%h exp=%h", i, got[i], want[i]); end
        end
    endtask

    task automatic test_fill_overflow();
        logic [DW-1:0] data[17];
        for (int i = 0; i < 17; i++) begin
            data[i] = DW'($urandom_range(0, 255));
            drive(1, 0, 0, data[i], 0, 0);
            if (i == 10 || i == 11) begin
                n_checks++; if (rts_n !== (i == 11)) begin n_errors++; $display("FAIL fill_rts_after_%0d got=%b exp=%b", i + 1, rts_n, (i == 11)); end
            end
        end
        n_checks++; if (full !== 1'b1 || count !== 5'd16) begin n_errors++; $display("FAIL fill_full got=%b/%0d exp=1/16", full, count); end
        n_checks++; if (overflow !== 1'b1) begin n_errors++; $display("FAIL fill_overflow got=%b exp=1", overflow); end
        n_checks++; if (drop_count !== (STATS ? 16'd1 : 16'd0)) begin n_errors++; $display("FAIL fill_drop_count got=%0d exp=%0d", drop_count, STATS ? 1 : 0); end
        for (int i = 0; i < 16; i++) begin
            n_checks++; if (out_valid !== 1'b1 || out_data !== data[i]) begin n_errors++; $display("FAIL fill_pop[%0d] got=%b/%h exp=1/%h", i, out_valid, out_data, data[i]); end
            drive(0, 0, 0, '0, 1, 0);
        end
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL fill_17th_absent got=%b exp=0", out_valid); end
        drive(0, 0, 0, '0, 0, 1);
        n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL fill_clear got=%b exp=0", overflow); end
    endtask

    task automatic test_full_push_pop();
        logic [15:0] drops_before;
        logic [DW-1:0] first;
        first = 8'h10;
        for (int i = 0; i < 16; i++) drive(1, 0, 0, first + DW'(i), 0, 0);
        drops_before = drop_count;
        drive(1, 0, 0, 8'hAA, 1, 0);
        n_checks++; if (count !== 5'd16 || full !== 1'b1) begin n_errors++; $display("FAIL fpp_count got=%0d/%b exp=16/1", count, full); end
        n_checks++; if (overflow !== 1'b0 || drop_count !== drops_before) begin n_errors++; $display("FAIL fpp_no_drop got=%b/%0d exp=0/%0d", overflow, drop_count, drops_before); end
        n_checks++; if (out_data !== 8'h11) begin n_errors++; $display("FAIL fpp_head got=%h exp=11", out_data); end
        for (int i = 0; i < 15; i++) drive(0, 0, 0, '0, 1, 0);
        n_checks++; if (count !== 5'd1 || out_data !== 8'hAA) begin n_errors++; $display("FAIL fpp_last got=%0d/%h exp=1/aa", count, out_data); end
        drain();
    endtask

    task automatic test_break_collapse();
        repeat (3) drive(0, 0, 1, 8'hFF, 0, 0);
        drive(1, 0, 0, 8'h55, 0, 0);
        n_checks++; if (count !== 5'd2) begin n_errors++; $display("FAIL brk_count got=%0d exp=2", count); end
        n_checks++; if ({out_brk, out_err, out_data} !== {2'b10, 8'h00}) begin n_errors++; $display("FAIL brk_head got=%b%b/%h exp=10/00", out_brk, out_err, out_data); end
        drive(0, 0, 0, '0, 1, 0);
        n_checks++; if ({out_brk, out_err, out_data} !== {2'b00, 8'h55}) begin n_errors++; $display("FAIL brk_second got=%b%b/%h exp=00/55", out_brk, out_err, out_data); end
        drain();
    endtask

    task automatic test_error_tag();
        drive(0, 1, 0, 8'h7E, 0, 0);
        n_checks++; if ({out_valid, out_err, out_brk, out_data} !== {3'b110, 8'h7E}) begin n_errors++; $display("FAIL err_head got=%b%b%b/%h exp=110/7e", out_valid, out_err, out_brk, out_data); end
        n_checks++; if (err_count !== (STATS ? 16'd1 : 16'd0)) begin n_errors++; $display("FAIL err_count got=%0d exp=%0d", err_count, STATS ? 1 : 0); end
        drain();
    endtask

    task automatic test_drop_clear();
        for (int i = 0; i < 16; i++) drive(1, 0, 0, DW'(i), 0, 0);
        drive(1, 0, 0, 8'hEE, 0, 1);
        n_checks++; if (overflow !== 1'b1) begin n_errors++; $display("FAIL dropclr_set_wins got=%b exp=1", overflow); end
        drive(0, 0, 0, '0, 0, 1);
        n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL dropclr_clear got=%b exp=0", overflow); end
        drain();
    endtask

    task automatic test_random();
        logic [SW-1:0] got, exp;
        int sel;
        logic rdy;
        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 9);
            rdy = (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            drive(sel < 4, sel == 4, sel == 5 || sel == 6, DW'($urandom), rdy, $urandom_range(0, 15) == 0);
            got = {out_valid, out_brk, out_err, out_data, count, full, rts_n, overflow};
            exp = exp_status();
            n_checks++; if (got !== exp) begin n_errors++; $display("FAIL rand_status[%0d] got=%h exp=%h", i, got, exp); end
            n_checks++; if ({drop_count, err_count} !== {exp_drop(), exp_err()}) begin n_errors++; $display("FAIL rand_counters[%0d] got=%0d/%0d exp=%0d/%0d", i, drop_count, err_count, exp_drop(), exp_err()); end
        end
        drain();
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 13; i++) drive(1, 0, 0, DW'($urandom), 0, 0);
        n_checks++; if (rts_n !== 1'b1 || count !== 5'd13) begin n_errors++; $display("FAIL arst_pre got=%b/%0d exp=1/13", rts_n, count); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if ({out_valid, rts_n, full} !== 3'b000 || count !== 5'd0) begin n_errors++; $display("FAIL arst_immediate got=%b%b%b/%0d exp=000/0", out_valid, rts_n, full, count); end
        in_valid = 0; in_error = 0; in_break = 0; out_ready = 0; clear_overflow = 0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 0, 0, 8'h3C, 0, 0);
        n_checks++; if ({out_valid, out_data, count} !== {1'b1, 8'h3C, 5'd1}) begin n_errors++; $display("FAIL arst_after got=%b/%h/%0d exp=1/3c/1", out_valid, out_data, count); end
        drain();
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_fill_overflow();
        test_full_push_pop();
        test_break_collapse();
        test_error_tag();
        test_drop_clear();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
